clz_dec: RTL and testbench

Multi-cycle leading-zero decoder for the 54-instruction CPU: the inverse of the count-leading-zeros unit. Given a count `n` (0..32), it builds a 32-bit word with exactly `n` leading zeros, either as a one-hot word (single 1 after the zeros) or as a mask (all 1s after the zeros). It sits beside the ALU as a start/done functional unit, with the controller stalling while `busy` is high.

---
 rtl/clz_dec_pkg.sv | 32 +++
 rtl/clz_dec_if.sv | 31 +++
 rtl/clz_dec_shift.sv | 22 ++
 rtl/clz_dec.sv | 105 ++++++++++
 tb/tb_clz_dec.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/clz_dec_pkg.sv
// rtl/clz_dec_pkg.sv - shared types, constants and helpers for the leading-zero decoder
// Purpose: state encoding, width/count limits, seed words, mode encodings,
//          count saturation and seed selection used by every clz_dec file.
// Ports:   none (package).
package clz_dec_pkg;

  localparam int CLZ_DEC_W    = 32;
  localparam int CLZ_DEC_NMAX = 32;
  localparam int CLZ_DEC_CW   = 6;

  localparam logic [CLZ_DEC_W-1:0] ONEHOT_SEED = 32'h8000_0000;
  localparam logic [CLZ_DEC_W-1:0] MASK_SEED   = 32'hFFFF_FFFF;

  localparam logic MODE_ONEHOT = 1'b0;
  localparam logic MODE_MASK   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counts above the word width all mean "every bit is a leading zero".
  function automatic logic [CLZ_DEC_CW-1:0] sat_count(input logic [CLZ_DEC_CW-1:0] n);
    return (n > CLZ_DEC_CW'(CLZ_DEC_NMAX)) ? CLZ_DEC_CW'(CLZ_DEC_NMAX) : n;
  endfunction

  function automatic logic [CLZ_DEC_W-1:0] seed_for(input logic mode);
    return (mode == MODE_MASK) ? MASK_SEED : ONEHOT_SEED;
  endfunction

endpackage

// File: rtl/clz_dec_if.sv
// rtl/clz_dec_if.sv - start/done request interface of the leading-zero decoder
// Purpose: bundles the request (start, n, mode) and response (busy, done, out).
// Ports (signals):
//   start  1   request strobe, sampled when the unit is not busy
//   n      6   leading-zero count (saturates to 32 at capture)
//   mode   1   0 = one-hot result, 1 = mask result
//   busy   1   unit is computing
//   done   1   one-cycle completion pulse
//   out    32  result word, held until the next accepted request
// Modports: master drives the request, slave (the decoder) drives the response.
interface clz_dec_if;
  import clz_dec_pkg::*;

  logic                  start;
  logic [CLZ_DEC_CW-1:0] n;
  logic                  mode;
  logic                  busy;
  logic                  done;
  logic [CLZ_DEC_W-1:0]  out;

  modport master (
    output start, n, mode,
    input  busy, done, out
  );

  modport slave (
    input  start, n, mode,
    output busy, done, out
  );

endinterface

// File: rtl/clz_dec_shift.sv
// rtl/clz_dec_shift.sv - combinational seed-plus-count barrel shifter
// Purpose: produces seed(mode) >> n in one step; used only when CLZ_DEC_FAST_EN
//          is defined.
// Ports:
//   i_mode  in   1   selects one-hot or mask seed
//   i_n     in   6   already-saturated shift count (0..32)
//   o_out   out  32  shifted seed; 0 when i_n is 32
module clz_dec_shift
  import clz_dec_pkg::*;
(
  input  logic                  i_mode,
  input  logic [CLZ_DEC_CW-1:0] i_n,
  output logic [CLZ_DEC_W-1:0]  o_out
);

  logic [CLZ_DEC_W-1:0] w_seed;

  assign w_seed = seed_for(i_mode);
  // A shift amount equal to the width yields all zeros, covering n = 32.
  assign o_out  = w_seed >> i_n;

endmodule

// File: rtl/clz_dec.sv
// rtl/clz_dec.sv - multi-cycle leading-zero decoder (inverse of count-leading-zeros)
// Purpose: builds a 32-bit word with exactly n leading zeros, one-hot or mask.
//          Build option CLZ_DEC_FAST_EN: single-cycle RUN using clz_dec_shift;
//          when undefined the result is shifted one bit per cycle.
// Ports:
//   clk   in  1   clock, rising edge
//   rst   in  1   asynchronous active-high reset
//   bus   slave modport of clz_dec_if (start, n, mode in; busy, done, out out)
module clz_dec
  import clz_dec_pkg::*;
#(
  parameter int W = CLZ_DEC_W
) (
  input  logic       clk,
  input  logic       rst,
  clz_dec_if.slave   bus
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CLZ_DEC_CW-1:0] r_cnt;
  logic [W-1:0]          r_out;
  logic                  w_accept;

`ifdef CLZ_DEC_FAST_EN
  logic                  r_mode;
  logic [W-1:0]          w_shift_out;

  clz_dec_shift u_shift (
    .i_mode (r_mode),
    .i_n    (r_cnt),
    .o_out  (w_shift_out)
  );
`endif

  // Requests arriving while a result is being built are dropped.
  assign w_accept = bus.start && (r_state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
`ifdef CLZ_DEC_FAST_EN
        w_state_nxt = DONE;
`else
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        // Holding start in the done cycle chains straight into the next request.
        w_state_nxt = bus.start ? RUN : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_out <= '0;
`ifdef CLZ_DEC_FAST_EN
      r_mode <= MODE_ONEHOT;
`endif
    end else if (w_accept) begin
      r_cnt <= sat_count(bus.n);
      r_out <= seed_for(bus.mode);
`ifdef CLZ_DEC_FAST_EN
      r_mode <= bus.mode;
`endif
    end else if (r_state == RUN) begin
`ifdef CLZ_DEC_FAST_EN
      r_out <= w_shift_out;
      r_cnt <= '0;
`else
      // One bit per cycle; the final cycle with cnt == 0 only hands off to DONE.
      if (r_cnt != '0) begin
        r_out <= r_out >> 1;
        r_cnt <= r_cnt - 1'b1;
      end
`endif
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.out  = r_out;

endmodule

// File: tb/tb_clz_dec.sv
// tb/tb_clz_dec.sv - directed self-checking bench for clz_dec
module tb_clz_dec;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  clz_dec_if bus ();

  clz_dec #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int          e;
  int          bc;
  int          dcount;
  logic [31:0] o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n > 32) ? 32 : n;
  endfunction

  // Edges from the accepting edge to the edge that enters DONE.
  function automatic int exp_lat(input int n);
`ifdef CLZ_DEC_FAST_EN
    return 1;
`else
    return sat(n) + 1;
`endif
  endfunction

  function automatic int clz(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) break;
      c++;
    end
    return c;
  endfunction

  task automatic do_start(input logic [5:0] nv, input logic m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nv;
    bus.mode  = m;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.n     = 6'h3f;
    bus.mode  = ~m;
  endtask

  // Samples at negedges; e = edges until done seen, bc = busy cycles before it.
  task automatic wait_done(output int ev, output int bcv, output logic [31:0] ov);
    ev  = 0;
    bcv = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && ev < 40) begin
      if (bus.busy === 1'b1) bcv++;
      @(negedge clk);
      ev++;
    end
    ov = bus.out;
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.n     = '0;
    bus.mode  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_out", bus.out, 32'h0);
    rst = 1'b0;

    // mode 0, n = 0
    do_start(6'd0, 1'b0);
    wait_done(e, bc, o);
    chk("n0_out", o, 32'h8000_0000);
    chk("n0_lat", 32'(e), 32'(exp_lat(0)));
    chk("n0_busy", 32'(bc), 32'(exp_lat(0)));
    chk("n0_busy_in_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("n0_done_pulse", 32'(bus.done), 32'd0);
    chk("n0_out_held", bus.out, 32'h8000_0000);

    // mode 1, n = 4
    do_start(6'd4, 1'b1);
    wait_done(e, bc, o);
    chk("n4m1_out", o, 32'h0FFF_FFFF);
    chk("n4m1_lat", 32'(e), 32'(exp_lat(4)));
    chk("n4m1_busy", 32'(bc), 32'(exp_lat(4)));

    // saturation
    do_start(6'd32, 1'b0);
    wait_done(e, bc, o);
    chk("n32_out", o, 32'h0);
    chk("n32_lat", 32'(e), 32'(exp_lat(32)));
    do_start(6'd45, 1'b0);
    wait_done(e, bc, o);
    chk("n45_out", o, 32'h0);
    chk("n45_lat", 32'(e), 32'(exp_lat(45)));
    do_start(6'd63, 1'b1);
    wait_done(e, bc, o);
    chk("n63m1_out", o, 32'h0);

    // start during RUN is ignored
    do_start(6'd10, 1'b0);
    @(negedge clk);
    chk("ign_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.n     = 6'd2;
    bus.mode  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(e, bc, o);
    chk("ign_out", o, 32'h0020_0000);
    chk("ign_lat", 32'(e + 1), 32'(exp_lat(10)));
    count_dones(40, dcount);
    chk("ign_single_done", 32'(dcount), 32'd0);
    chk("ign_idle_busy", 32'(bus.busy), 32'd0);
    chk("ign_out_held", bus.out, 32'h0020_0000);

    // reset mid-RUN
    do_start(6'd20, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out", bus.out, 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(40, dcount);
    chk("abort_no_done", 32'(dcount), 32'd0);
    do_start(6'd1, 1'b1);
    wait_done(e, bc, o);
    chk("after_abort_out", o, 32'h7FFF_FFFF);
    chk("after_abort_lat", 32'(e), 32'(exp_lat(1)));

    // sweep with back-to-back starts taken in each done cycle
    for (int m = 0; m < 2; m++) begin
      do_start(6'd0, m[0]);
      for (int k = 0; k <= 32; k++) begin
        wait_done(e, bc, o);
        chk($sformatf("sweep_m%0d_n%0d_clz", m, k), 32'(clz(o)), 32'(k));
        chk($sformatf("sweep_m%0d_n%0d_ones", m, k), 32'($countones(o)),
            (m == 1) ? 32'(32 - k) : ((k < 32) ? 32'd1 : 32'd0));
        chk($sformatf("sweep_m%0d_n%0d_lat", m, k), 32'(e), 32'(exp_lat(k)));
        chk($sformatf("sweep_m%0d_n%0d_busy", m, k), 32'(bc), 32'(exp_lat(k)));
        if (k < 32) begin
          bus.start = 1'b1;
          bus.n     = 6'(k + 1);
          bus.mode  = m[0];
          @(posedge clk);
          #1;
          bus.start = 1'b0;
          bus.n     = 6'h3f;
          bus.mode  = ~m[0];
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
